// File: rtl/clock_yyyy_calendar_if.sv
// Bus bundle for the year stage: rollover pulse, month digits, set-time
// write port, and the year digits / calendar qualifiers it returns.
interface clock_yyyy_calendar_if;
  logic       pulse_period_year;
  logic [3:0] counter_for_clock_10month;
  logic [3:0] counter_for_clock_month;
  logic       set_time_enable;
  logic       set_strobe;
  logic [3:0] set_digit;
  logic [3:0] new_value;
  logic [3:0] counter_for_clock_year;
  logic [3:0] counter_for_clock_10year;
  logic [3:0] counter_for_clock_100year;
  logic [3:0] counter_for_clock_1000year;
  logic       Is_Leap_Year;
  logic       Is_February;
  logic       Is_31_day;
  logic       year_wrap;

  modport master (
    output pulse_period_year, counter_for_clock_10month, counter_for_clock_month,
           set_time_enable, set_strobe, set_digit, new_value,
    input  counter_for_clock_year, counter_for_clock_10year,
           counter_for_clock_100year, counter_for_clock_1000year,
           Is_Leap_Year, Is_February, Is_31_day, year_wrap
  );

  modport slave (
    input  pulse_period_year, counter_for_clock_10month, counter_for_clock_month,
           set_time_enable, set_strobe, set_digit, new_value,
    output counter_for_clock_year, counter_for_clock_10year,
           counter_for_clock_100year, counter_for_clock_1000year,
           Is_Leap_Year, Is_February, Is_31_day, year_wrap
  );
endinterface

// File: rtl/clock_yyyy_calendar.sv
// Year stage of the calendar clock: four BCD year digits advanced by a
// synchronised rollover pulse, per-digit set writes, leap/month qualifiers.
module clock_yyyy_calendar #(
  parameter logic [15:0] RESET_YEAR = 16'h2000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  clock_yyyy_calendar_if.slave  cal
);

  function automatic logic div4(input logic [3:0] tens, input logic [3:0] ones);
    logic [4:0] s;
    s = {tens, 1'b0} + {1'b0, ones};
    return (s[1:0] == 2'b00);
  endfunction

  function automatic logic leap_of(input logic [15:0] y);
    if (y[7:0] != 8'h00) return div4(y[7:4], y[3:0]);
    else                 return div4(y[15:12], y[11:8]);
  endfunction

  logic [3:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic       leap_q, leap_d;
  logic       feb_q, feb_d;
  logic       d31_q, d31_d;
  logic       wrap_q, wrap_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0] fill_q, fill_d;
  logic       inc;
  logic       all_nines;

  always_comb begin
    sync1_d = cal.pulse_period_year;
    sync2_d = sync1_q;
    // For the two cycles after reset, sync3 shadows sync2's input so a pulse
    // already high at release is treated as seen rather than as a new edge.
    sync3_d = (fill_q != 2'd0) ? sync1_q : sync2_q;
    fill_d  = (fill_q != 2'd0) ? fill_q - 2'd1 : fill_q;
    inc     = sync2_q & ~sync3_q;
  end

  always_comb begin
    y0_d      = y0_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y3_d      = y3_q;
    wrap_d    = 1'b0;
    all_nines = (y0_q == 4'd9) && (y1_q == 4'd9) && (y2_q == 4'd9) && (y3_q == 4'd9);
    if (cal.set_time_enable) begin
      if (cal.set_strobe && (cal.new_value <= 4'd9)) begin
        case (cal.set_digit)
          4'd2:    y3_d = cal.new_value;
          4'd3:    y2_d = cal.new_value;
          4'd4:    y1_d = cal.new_value;
          4'd5:    y0_d = cal.new_value;
          default: ;
        endcase
      end
    end else if (inc) begin
      y0_d = (y0_q == 4'd9) ? 4'd0 : y0_q + 4'd1;
      if (y0_q == 4'd9) begin
        y1_d = (y1_q == 4'd9) ? 4'd0 : y1_q + 4'd1;
        if (y1_q == 4'd9) begin
          y2_d = (y2_q == 4'd9) ? 4'd0 : y2_q + 4'd1;
          if (y2_q == 4'd9) begin
            y3_d = (y3_q == 4'd9) ? 4'd0 : y3_q + 4'd1;
          end
        end
      end
      wrap_d = all_nines;
    end
  end

  always_comb begin
    leap_d = leap_of({y3_q, y2_q, y1_q, y0_q});
    feb_d  = 1'b0;
    d31_d  = 1'b0;
    // Out-of-range months (00, >12, non-BCD digits) fall through to zero.
    if (cal.counter_for_clock_10month == 4'd0) begin
      feb_d = (cal.counter_for_clock_month == 4'd2);
      d31_d = (cal.counter_for_clock_month == 4'd1) || (cal.counter_for_clock_month == 4'd3) ||
              (cal.counter_for_clock_month == 4'd5) || (cal.counter_for_clock_month == 4'd7) ||
              (cal.counter_for_clock_month == 4'd8);
    end else if (cal.counter_for_clock_10month == 4'd1) begin
      d31_d = (cal.counter_for_clock_month == 4'd0) || (cal.counter_for_clock_month == 4'd2);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y0_q    <= RESET_YEAR[3:0];
      y1_q    <= RESET_YEAR[7:4];
      y2_q    <= RESET_YEAR[11:8];
      y3_q    <= RESET_YEAR[15:12];
      leap_q  <= leap_of(RESET_YEAR);
      feb_q   <= 1'b0;
      d31_q   <= 1'b0;
      wrap_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      fill_q  <= 2'd2;
    end else begin
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      leap_q  <= leap_d;
      feb_q   <= feb_d;
      d31_q   <= d31_d;
      wrap_q  <= wrap_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      fill_q  <= fill_d;
    end
  end

  assign cal.counter_for_clock_year     = y0_q;
  assign cal.counter_for_clock_10year   = y1_q;
  assign cal.counter_for_clock_100year  = y2_q;
  assign cal.counter_for_clock_1000year = y3_q;
  assign cal.Is_Leap_Year               = leap_q;
  assign cal.Is_February                = feb_q;
  assign cal.Is_31_day                  = d31_q;
  assign cal.year_wrap                  = wrap_q;

endmodule

// File: tb/tb_clock_yyyy_calendar.sv
// Self-checking bench for clock_yyyy_calendar against an integer-year
// Gregorian reference model with randomized writes, pulses and months.
module tb_clock_yyyy_calendar;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   m_year = 2000;

  clock_yyyy_calendar_if cal();

  clock_yyyy_calendar #(.RESET_YEAR(16'h2000)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .cal   (cal.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [15:0] to_bcd(input int y);
    logic [15:0] r;
    r[15:12] = 4'(y / 1000);
    r[11:8]  = 4'((y / 100) % 10);
    r[7:4]   = 4'((y / 10) % 10);
    r[3:0]   = 4'(y % 10);
    return r;
  endfunction

  function automatic logic is_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic logic [1:0] month_flags(input int m10, input int m1);
    int m;
    if (m10 > 9 || m1 > 9) return 2'b00;
    m = m10 * 10 + m1;
    return {(m == 2), (m inside {1, 3, 5, 7, 8, 10, 12})};
  endfunction

  function automatic logic [15:0] dut_year();
    return {cal.counter_for_clock_1000year, cal.counter_for_clock_100year,
            cal.counter_for_clock_10year, cal.counter_for_clock_year};
  endfunction

  task automatic write_digit(input int dig, input int val);
    cal.set_time_enable = 1'b1;
    cal.set_strobe      = 1'b1;
    cal.set_digit       = dig[3:0];
    cal.new_value       = val[3:0];
    tick();
    cal.set_strobe      = 1'b0;
    if (dig >= 2 && dig <= 5 && val <= 9) begin
      int d[4];
      d[0] = m_year % 10; d[1] = (m_year / 10) % 10;
      d[2] = (m_year / 100) % 10; d[3] = m_year / 1000;
      d[5 - dig] = val;
      m_year = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    end
  endtask

  task automatic set_year(input int y);
    write_digit(2, y / 1000);
    write_digit(3, (y / 100) % 10);
    write_digit(4, (y / 10) % 10);
    write_digit(5, y % 10);
    cal.set_time_enable = 1'b0;
    tick(2);
    chk("set_year", dut_year(), to_bcd(m_year));
  endtask

  task automatic pulse_year();
    int old;
    old = m_year;
    cal.pulse_period_year = 1'b1;
    tick(2);
    chk("inc_early", dut_year(), to_bcd(old));
    tick();
    m_year = (old + 1) % 10000;
    chk("inc_year", dut_year(), to_bcd(m_year));
    chk("wrap_on", cal.year_wrap, (old == 9999));
    chk("leap_lag", cal.Is_Leap_Year, is_leap(old));
    tick();
    chk("leap_new", cal.Is_Leap_Year, is_leap(m_year));
    chk("wrap_off", cal.year_wrap, 1'b0);
    cal.pulse_period_year = 1'b0;
    tick(3);
  endtask

  task automatic set_month(input int m10, input int m1);
    logic [1:0] f;
    cal.counter_for_clock_10month = m10[3:0];
    cal.counter_for_clock_month   = m1[3:0];
    f = month_flags(m10, m1);
    tick();
    chk("is_feb", cal.Is_February, f[1]);
    chk("is_31", cal.Is_31_day, f[0]);
  endtask

  initial begin
    cal.pulse_period_year         = 1'b0;
    cal.counter_for_clock_10month = 4'd0;
    cal.counter_for_clock_month   = 4'd2;
    cal.set_time_enable           = 1'b0;
    cal.set_strobe                = 1'b0;
    cal.set_digit                 = 4'd0;
    cal.new_value                 = 4'd0;
    tick(2);
    RST_N = 1'b1;
    chk("rst_feb", cal.Is_February, 1'b0);
    tick();
    chk("feb_after_rst", cal.Is_February, 1'b1);
    tick(2);
    chk("rst_year", dut_year(), 16'h2000);
    chk("rst_leap", cal.Is_Leap_Year, 1'b1);
    chk("rst_wrap", cal.year_wrap, 1'b0);

    set_year(2099); pulse_year();
    set_year(2399); pulse_year();
    set_year(9999); pulse_year();
    set_year(2023); pulse_year();

    for (int m = 0; m <= 13; m++) set_month(m / 10, m % 10);
    set_month(1, 5);
    set_month(0, 2);

    // Pulse during set mode is dropped.
    cal.set_time_enable   = 1'b1;
    cal.pulse_period_year = 1'b1;
    tick(5);
    cal.pulse_period_year = 1'b0;
    tick(3);
    cal.set_time_enable   = 1'b0;
    tick(3);
    chk("set_mode_pulse", dut_year(), to_bcd(m_year));

    write_digit(5, 10);
    cal.set_time_enable = 1'b0;
    tick();
    chk("bad_value", dut_year(), to_bcd(m_year));
    write_digit(4, 7);
    cal.set_time_enable = 1'b0;
    chk("tens_write", cal.counter_for_clock_10year, 4'd7);
    tick();
    chk("tens_leap", cal.Is_Leap_Year, is_leap(m_year));

    cal.pulse_period_year = 1'b1;
    tick(50);
    m_year = (m_year + 1) % 10000;
    chk("held_pulse", dut_year(), to_bcd(m_year));
    cal.pulse_period_year = 1'b0;
    tick(4);
    chk("held_once", dut_year(), to_bcd(m_year));

    // Reset lands while a pulse is in the synchronizer and is still high at release.
    cal.pulse_period_year = 1'b1;
    tick();
    RST_N = 1'b0;
    #2;
    m_year = 2000;
    chk("async_rst", dut_year(), 16'h2000);
    tick();
    RST_N = 1'b1;
    tick(6);
    chk("no_inc_rel", dut_year(), 16'h2000);
    cal.pulse_period_year = 1'b0;
    tick(4);
    chk("no_inc_late", dut_year(), 16'h2000);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: pulse_year();
        1: begin
          write_digit($urandom_range(0, 7), $urandom_range(0, 15));
          cal.set_time_enable = 1'b0;
          chk("rnd_write", dut_year(), to_bcd(m_year));
          tick();
          chk("rnd_leap", cal.Is_Leap_Year, is_leap(m_year));
        end
        2: set_month($urandom_range(0, 2), $urandom_range(0, 15));
        default: begin
          set_year($urandom_range(0, 9999));
          pulse_year();
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
